// File: rtl/cpu_pkg.sv
// Shared CPU decode/execute definitions: immediate extension mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int EXT_OP_W = 3;

   // Extension modes; any encoding with bit 2 set is illegal.
   localparam logic [EXT_OP_W-1:0] EXT_ZERO  = 3'b000;
   localparam logic [EXT_OP_W-1:0] EXT_SIGN  = 3'b001;
   localparam logic [EXT_OP_W-1:0] EXT_HIGH  = 3'b010;
   localparam logic [EXT_OP_W-1:0] EXT_SSHL2 = 3'b011;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Decode->execute immediate channel: input handshake with raw immediate/op/tag, output handshake with result.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready valid-ready pairs.
// Modports: master = upstream/downstream environment, slave = the extender pipe stage.
interface imm_ext_pipe_if
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 8
) ();

   logic                in_valid;
   logic                in_ready;
   logic [IN_W-1:0]     in_imm;
   logic [EXT_OP_W-1:0] in_op;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [OUT_W-1:0]    out_imm;
   logic [TAG_W-1:0]    out_tag;
   logic                out_err;

   modport master (
      output in_valid, in_imm, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_imm, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_err
   );

endinterface

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: (imm_i, op_i) -> (imm_o, err_o).
// Latency: 0 cycles.
// Backpressure: none (no state).
// Ports: imm_i raw immediate, op_i extension mode, imm_o extended value, err_o illegal mode.
module imm_ext_core
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]     imm_i,
   input  logic [EXT_OP_W-1:0] op_i,
   output logic [OUT_W-1:0]    imm_o,
   output logic                err_o
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

   always_comb begin
      imm_o = '0;
      err_o = 1'b0;
      case (op_i)
         EXT_ZERO:  imm_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
         EXT_SIGN:  imm_o = sext;
         EXT_HIGH:  imm_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
         // Branch offsets: word-scaled sign extension, top two bits fall off.
         EXT_SSHL2: imm_o = {sext[OUT_W-3:0], 2'b00};
         default:   err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender between decode and execute with a head + skid register pair (strict FIFO).
// Latency: 1 cycle from accept to out_valid when empty.
// Backpressure: in_ready = !skid_valid (state only); outputs held stable while out_valid && !out_ready.
// Ports: clk, rst (sync, active-high), flush (only with IMM_EXT_FLUSH_EN defined), bus (imm_ext_pipe_if.slave).
module imm_ext_pipe
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 8
) (
   input  logic clk,
   input  logic rst,
`ifdef IMM_EXT_FLUSH_EN
   input  logic flush,
`endif
   imm_ext_pipe_if.slave bus
);

   logic flush_w;
`ifdef IMM_EXT_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   logic [OUT_W-1:0] ext_imm;
   logic             ext_err;

   imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .imm_i (bus.in_imm),
      .op_i  (bus.in_op),
      .imm_o (ext_imm),
      .err_o (ext_err)
   );

   logic             head_vld_q, head_vld_d;
   logic [OUT_W-1:0] head_imm_q, head_imm_d;
   logic [TAG_W-1:0] head_tag_q, head_tag_d;
   logic             head_err_q, head_err_d;
   logic             skid_vld_q, skid_vld_d;
   logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_err_q, skid_err_d;

   logic push;
   logic pop;

   // A push coinciding with flush is discarded.
   assign push = bus.in_valid && !skid_vld_q && !flush_w;
   assign pop  = head_vld_q && bus.out_ready;

   always_comb begin
      head_vld_d = head_vld_q;
      head_imm_d = head_imm_q;
      head_tag_d = head_tag_q;
      head_err_d = head_err_q;
      skid_vld_d = skid_vld_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_err_d = skid_err_q;

      if (pop) begin
         if (skid_vld_q) begin
            head_vld_d = 1'b1;
            head_imm_d = skid_imm_q;
            head_tag_d = skid_tag_q;
            head_err_d = skid_err_q;
            skid_vld_d = 1'b0;
         end else begin
            head_vld_d = 1'b0;
         end
      end

      if (push) begin
         // Head is free (or drains this cycle with nothing behind it): new data goes straight to the head.
         if (!head_vld_q || (pop && !skid_vld_q)) begin
            head_vld_d = 1'b1;
            head_imm_d = ext_imm;
            head_tag_d = bus.in_tag;
            head_err_d = ext_err;
         end else begin
            skid_vld_d = 1'b1;
            skid_imm_d = ext_imm;
            skid_tag_d = bus.in_tag;
            skid_err_d = ext_err;
         end
      end

      // Flush drops occupancy only; data registers keep their contents.
      if (flush_w) begin
         head_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_vld_q <= 1'b0;
         head_imm_q <= '0;
         head_tag_q <= '0;
         head_err_q <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         head_vld_q <= head_vld_d;
         head_imm_q <= head_imm_d;
         head_tag_q <= head_tag_d;
         head_err_q <= head_err_d;
         skid_vld_q <= skid_vld_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_err_q <= skid_err_d;
      end
   end

   assign bus.in_ready  = !skid_vld_q;
   assign bus.out_valid = head_vld_q;
   assign bus.out_imm   = head_imm_q;
   assign bus.out_tag   = head_tag_q;
   assign bus.out_err   = head_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and randomized-stream bench for imm_ext_pipe (IN_W=16, OUT_W=32, TAG_W=8).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Flush scenario compiled in only with IMM_EXT_FLUSH_EN defined.
module tb_imm_ext_pipe;
   import cpu_pkg::*;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int TAG_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

`ifdef IMM_EXT_FLUSH_EN
   logic flush;
`endif

   imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef IMM_EXT_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   // Reference extension: returns {err, imm32}.
   function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [15:0] imm);
      case (op)
         3'd0:    return {1'b0, 16'h0000, imm};
         3'd1:    return {1'b0, {16{imm[15]}}, imm};
         3'd2:    return {1'b0, imm, 16'h0000};
         3'd3:    return {1'b0, {14{imm[15]}}, imm, 2'b00};
         default: return {1'b1, 32'h0000_0000};
      endcase
   endfunction

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_imm   = '0;
      bus.in_op    = '0;
      bus.in_tag   = '0;
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] imm, input logic [7:0] tag);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_imm   = imm;
      bus.in_tag   = tag;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready); end
      total++; if (bus.out_imm !== 32'h0) begin bad++; $display("FAIL reset_out_imm: got %0h want 0", bus.out_imm); end
      total++; if (bus.out_tag !== 8'h0) begin bad++; $display("FAIL reset_out_tag: got %0h want 0", bus.out_tag); end
      total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %0h want 0", bus.out_err); end
   endtask

   task automatic test_modes();
      logic [2:0]  ops  [4] = '{EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_SSHL2};
      logic [15:0] imms [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
      logic [31:0] exps [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'h1234_0000, 32'hFFFF_FFFC};
      bus.out_ready = 1'b1;
      drive(ops[0], imms[0], 8'h10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_valid: got %0h want 1", i, bus.out_valid); end
         total++; if (bus.out_imm !== exps[i]) begin bad++; $display("FAIL mode%0d_imm: got %08h want %08h", i, bus.out_imm, exps[i]); end
         total++; if (bus.out_tag !== 8'(8'h10 + i)) begin bad++; $display("FAIL mode%0d_tag: got %0h want %0h", i, bus.out_tag, 8'(8'h10 + i)); end
         total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL mode%0d_err: got %0h want 0", i, bus.out_err); end
         if (i < 3) drive(ops[i+1], imms[i+1], 8'(8'h11 + i));
         else       idle();
      end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL modes_drain: got %0h want 0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive(3'b101, 16'h7FFF, 8'h5A);
      @(negedge clk);
      idle();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid: got %0h want 1", bus.out_valid); end
      total++; if (bus.out_imm !== 32'h0) begin bad++; $display("FAIL illegal_imm: got %08h want 0", bus.out_imm); end
      total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %0h want 1", bus.out_err); end
      total++; if (bus.out_tag !== 8'h5A) begin bad++; $display("FAIL illegal_tag: got %0h want 5a", bus.out_tag); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(EXT_ZERO, 16'h0101, 8'h01);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1: got %0h want 1", bus.in_ready); end
      total++; if (bus.out_tag !== 8'h01 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_head1: got v=%0h tag=%0h want v=1 tag=01", bus.out_valid, bus.out_tag); end
      drive(EXT_ZERO, 16'h0202, 8'h02);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after2: got %0h want 0", bus.in_ready); end
      drive(EXT_ZERO, 16'h0303, 8'h03);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %0h want 0", bus.in_ready); end
      total++; if (bus.out_tag !== 8'h01 || bus.out_imm !== 32'h0000_0101) begin bad++; $display("FAIL bp_hold: got tag=%0h imm=%08h want tag=01 imm=00000101", bus.out_tag, bus.out_imm); end
      idle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'h02 || bus.out_imm !== 32'h0000_0202) begin bad++; $display("FAIL bp_second: got v=%0h tag=%0h imm=%08h want v=1 tag=02 imm=00000202", bus.out_valid, bus.out_tag, bus.out_imm); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_third: got v=%0h tag=%0h want v=0", bus.out_valid, bus.out_tag); end
   endtask

   task automatic test_stream();
      logic [40:0] q[$];
      logic [40:0] exp_v;
      logic [40:0] held;
      logic [40:0] got;
      logic [32:0] r;
      logic [2:0]  op;
      logic [15:0] imm;
      logic        hold_chk = 1'b0;
      int sent = 0;
      int rcvd = 0;
      int cyc  = 0;
      while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
         got = {bus.out_tag, bus.out_err, bus.out_imm};
         if (hold_chk) begin
            total++; if (got !== held) begin bad++; $display("FAIL stream_hold: got %h want %h", got, held); end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 100 && $urandom_range(0, 3) != 0) begin
            op  = 3'($urandom_range(0, 7));
            imm = 16'($urandom);
            drive(op, imm, 8'(sent));
         end else begin
            idle();
         end
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL stream_extra: got %h want none", got);
            end else begin
               exp_v = q.pop_front();
               if (got !== exp_v) begin bad++; $display("FAIL stream_item%0d: got %h want %h", rcvd, got, exp_v); end
            end
            rcvd++;
         end
         hold_chk = bus.out_valid && !bus.out_ready;
         held     = got;
         if (bus.in_valid && bus.in_ready) begin
            r = ref_ext(bus.in_op, bus.in_imm);
            q.push_back({bus.in_tag, r});
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      idle();
      total++; if (rcvd != 100 || q.size() != 0) begin bad++; $display("FAIL stream_count: got rcvd=%0d pending=%0d want rcvd=100 pending=0", rcvd, q.size()); end
   endtask

   task automatic test_reset_full();
      bus.out_ready = 1'b0;
      drive(EXT_SIGN, 16'h8000, 8'hA1);
      @(negedge clk);
      drive(EXT_SIGN, 16'h8000, 8'hA2);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0 || bus.out_imm !== 32'hFFFF_8000) begin bad++; $display("FAIL rstfull_pre: got rdy=%0h imm=%08h want rdy=0 imm=ffff8000", bus.in_ready, bus.out_imm); end
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(EXT_HIGH, 16'hBEEF, 8'hA3);
      @(negedge clk);
      rst = 1'b0;
      idle();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_valid: got %0h want 0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_ready: got %0h want 1", bus.in_ready); end
      total++; if (bus.out_imm !== 32'h0 || bus.out_tag !== 8'h0 || bus.out_err !== 1'b0) begin bad++; $display("FAIL rstfull_data: got imm=%08h tag=%0h err=%0h want 0", bus.out_imm, bus.out_tag, bus.out_err); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_stays_empty: got %0h want 0", bus.out_valid); end
   endtask

`ifdef IMM_EXT_FLUSH_EN
   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive(EXT_ZERO, 16'h1111, 8'h71);
      @(negedge clk);
      drive(EXT_ZERO, 16'h2222, 8'h72);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full: got %0h want 0", bus.in_ready); end
      // in_ready is 0 while full; the concurrent push must be discarded either way.
      flush = 1'b1;
      drive(EXT_ZERO, 16'h7777, 8'h77);
      @(negedge clk);
      flush = 1'b0;
      idle();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0h want 0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %0h want 1", bus.in_ready); end
      // Flush with head only valid and a live push: push is also dropped.
      drive(EXT_ZERO, 16'h3333, 8'h73);
      @(negedge clk);
      flush = 1'b1;
      drive(EXT_ZERO, 16'h7878, 8'h78);
      @(negedge clk);
      flush = 1'b0;
      idle();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_nothing_%0d: got v=%0h tag=%0h want v=0", i, bus.out_valid, bus.out_tag); end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef IMM_EXT_FLUSH_EN
      flush = 1'b0;
`endif
      test_reset();
      test_modes();
      test_illegal();
      test_backpressure();
      test_stream();
      test_reset_full();
`ifdef IMM_EXT_FLUSH_EN
      test_flush();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
